// File: rtl/mux_arbiter_pkg.sv
// Shared types and default constants for the two-requester mux arbiter.
package mux_arbiter_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_MAX_HOLD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GNT_A = 2'b01,
    GNT_B = 2'b10
  } state_e;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

  // Last hold count a grant may reach before a contested handover (1..15 legal).
  function automatic logic [3:0] holdLimit(input int maxHold);
    return 4'(maxHold - 1);
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Request/grant and data bundle between the two requesters and the arbiter.
interface mux_arbiter_if
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             req_a;
  logic             req_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             gnt_a;
  logic             gnt_b;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  modport master (
    output req_a, req_b, a, b,
    input  gnt_a, gnt_b, sel, y, y_valid
  );

  modport slave (
    input  req_a, req_b, a, b,
    output gnt_a, gnt_b, sel, y, y_valid
  );

endinterface

// File: rtl/mux_arbiter_mux2.sv
// One-bit 2:1 multiplexer built from gate primitives: y = sel ? b : a.
module mux_arbiter_mux2 (
  input  wire a,
  input  wire b,
  input  wire sel,
  output wire y
);

  wire selN;
  wire pickA;
  wire pickB;

  not u_inv  (selN, sel);
  and u_andA (pickA, a, selN);
  and u_andB (pickB, b, sel);
  or  u_or   (y, pickA, pickB);

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with bounded hold time driving a gate-level shared mux.
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_arbiter_if.slave  arb_io
);

  localparam logic [3:0] HOLD_LAST = holdLimit(MAX_HOLD);

  state_e     state_q, state_d;
  logic [3:0] holdCnt_q, holdCnt_d;
  side_e      lastGnt_q, lastGnt_d;
  logic       sel_q, sel_d;
  wire  [WIDTH-1:0] yBits;

  // lastGnt resets to B so that A wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      holdCnt_q <= 4'd0;
      lastGnt_q <= SIDE_B;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      holdCnt_q <= holdCnt_d;
      lastGnt_q <= lastGnt_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    lastGnt_d = lastGnt_q;
    sel_d     = sel_q;

    case (state_q)
      IDLE: begin
        if (arb_io.req_a && !arb_io.req_b) begin
          state_d = GNT_A;
        end else if (!arb_io.req_a && arb_io.req_b) begin
          state_d = GNT_B;
        end else if (arb_io.req_a && arb_io.req_b) begin
          state_d = (lastGnt_q == SIDE_B) ? GNT_A : GNT_B;
        end
      end
      GNT_A: begin
        if (!arb_io.req_a) begin
          state_d = arb_io.req_b ? GNT_B : IDLE;
        end else if (arb_io.req_b && (holdCnt_q == HOLD_LAST)) begin
          state_d = GNT_B;
        end
      end
      GNT_B: begin
        if (!arb_io.req_b) begin
          state_d = arb_io.req_a ? GNT_A : IDLE;
        end else if (arb_io.req_a && (holdCnt_q == HOLD_LAST)) begin
          state_d = GNT_A;
        end
      end
      default: state_d = IDLE;
    endcase

    // Count restarts on every grant entry and saturates while the grant is kept.
    if (state_d == IDLE || state_d != state_q) begin
      holdCnt_d = 4'd0;
    end else if (holdCnt_q != HOLD_LAST) begin
      holdCnt_d = holdCnt_q + 4'd1;
    end

    if (state_d == GNT_A) begin
      lastGnt_d = SIDE_A;
      sel_d     = 1'b0;
    end else if (state_d == GNT_B) begin
      lastGnt_d = SIDE_B;
      sel_d     = 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_arbiter_mux2 u_mux2 (
      .a   (arb_io.a[i]),
      .b   (arb_io.b[i]),
      .sel (sel_q),
      .y   (yBits[i])
    );
  end

  assign arb_io.gnt_a   = (state_q == GNT_A);
  assign arb_io.gnt_b   = (state_q == GNT_B);
  assign arb_io.sel     = sel_q;
  assign arb_io.y       = yBits;
  assign arb_io.y_valid = (state_q == GNT_A) || (state_q == GNT_B);

endmodule

// File: tb/tb_mux_arbiter.sv
// Scenario bench for mux_arbiter: WIDTH=8/MAX_HOLD=4 and WIDTH=1/MAX_HOLD=1 instances.
`timescale 1ns/1ps
module tb_mux_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_arbiter_if #(.WIDTH(8)) bus0 ();
  mux_arbiter_if #(.WIDTH(1)) bus1 ();

  mux_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_io (bus0)
  );

  mux_arbiter #(.WIDTH(1), .MAX_HOLD(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_io (bus1)
  );

  typedef struct packed {
    logic       gntA;
    logic       gntB;
    logic       sel;
    logic       yValid;
    logic [7:0] y;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  function automatic obs_t mk(input logic ga, input logic gb, input logic s,
                              input logic v, input logic [7:0] yv);
    obs_t r;
    r.gntA   = ga;
    r.gntB   = gb;
    r.sel    = s;
    r.yValid = v;
    r.y      = yv;
    return r;
  endfunction

  function automatic obs_t obs0();
    return mk(bus0.gnt_a, bus0.gnt_b, bus0.sel, bus0.y_valid, bus0.y);
  endfunction

  function automatic obs_t obs1();
    return mk(bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.y_valid, {7'd0, bus1.y});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic ra, input logic rb, input logic [7:0] av, input logic [7:0] bv);
    bus0.req_a = ra;
    bus0.req_b = rb;
    bus0.a     = av;
    bus0.b     = bv;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst_n = 1'b0;
    drive0(1'b0, 1'b0, 8'h11, 8'h22);
    #1;
    expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
    exp = expQ.pop_front();
    got = obs0();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_state: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
               got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
    // A request while reset is held must not produce a grant.
    drive0(1'b1, 1'b1, 8'h11, 8'h22);
    expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h11));
    tick();
    exp = expQ.pop_front();
    got = obs0();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL reset_held: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
               got[11:8], got[7:0], exp[11:8], exp[7:0]);
    end
    drive0(1'b0, 1'b0, 8'h11, 8'h22);
  endtask

  task automatic test_single_a();
    obs_t got, exp;
    obs_t exps[4];
    applyReset();
    exps[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C);
    exps[1] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h3C);
    exps[2] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'hE1);
    exps[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'hE1);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drive0(1'b1, 1'b0, 8'h3C, 8'h00);
        2: drive0(1'b1, 1'b0, 8'hE1, 8'h00);
        3: drive0(1'b0, 1'b0, 8'hE1, 8'h00);
        default: ;
      endcase
      expQ.push_back(exps[i]);
      if (i == 0 || i == 2) #1;
      else tick();
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL single_a step %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_tie();
    obs_t got, exp;
    logic isA;
    tick();
    applyReset();
    drive0(1'b1, 1'b1, 8'h5A, 8'hC3);
    for (int i = 0; i < 16; i++) begin
      isA = (((i / 4) % 2) == 0);
      expQ.push_back(mk(isA, !isA, !isA, 1'b1, isA ? 8'h5A : 8'hC3));
      tick();
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp || (got.gntA && got.gntB)) begin
        errors++;
        $display("[TB] FAIL tie cycle %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_handover();
    obs_t got, exp;
    tick();
    applyReset();
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        drive0(1'b1, 1'b0, 8'h11, 8'hA5);
        expQ.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h11));
      end else begin
        // Later cycles also cover an uncontested grant being held indefinitely.
        drive0(1'b0, 1'b1, 8'h11, 8'hA5);
        expQ.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5));
      end
      tick();
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL handover cycle %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_idle();
    obs_t got, exp;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        drive0(1'b0, 1'b0, 8'h11, 8'hA5);
        expQ.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5));
      end else begin
        drive0(1'b0, 1'b1, 8'h11, 8'h3D);
        expQ.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h3D));
      end
      tick();
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL idle cycle %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_idle_tie();
    obs_t got, exp;
    logic [1:0] reqs[4];
    obs_t exps[4];
    reqs[0] = 2'b00;
    reqs[1] = 2'b11;
    reqs[2] = 2'b00;
    reqs[3] = 2'b11;
    exps[0] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h88);
    exps[1] = mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h44);
    exps[2] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h44);
    exps[3] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h88);
    for (int i = 0; i < 4; i++) begin
      drive0(reqs[i][1], reqs[i][0], 8'h44, 8'h88);
      expQ.push_back(exps[i]);
      tick();
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL idle_tie step %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t got, exp;
    tick();
    applyReset();
    drive0(1'b0, 1'b1, 8'h69, 8'h96);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: expQ.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 8'h96));
        1: expQ.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h69));
        default: expQ.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8'h69));
      endcase
      if (i == 1) begin
        rst_n = 1'b0;
        #1;
      end else begin
        tick();
      end
      exp = expQ.pop_front();
      got = obs0();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL reset_mid step %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
      if (i == 1) begin
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, 8'h69, 8'h96);
      end
    end
  endtask

  task automatic test_alternate();
    obs_t got, exp;
    logic isA;
    tick();
    applyReset();
    bus1.req_a = 1'b1;
    bus1.req_b = 1'b1;
    bus1.a     = 1'b1;
    bus1.b     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      isA = ((i % 2) == 0);
      expQ.push_back(mk(isA, !isA, !isA, 1'b1, isA ? 8'h01 : 8'h00));
      tick();
      exp = expQ.pop_front();
      got = obs1();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL alternate cycle %0d: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                 i, got[11:8], got[7:0], exp[11:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_mux_sweep();
    obs_t got, exp;
    logic av, bv, yv;
    for (int s = 0; s < 2; s++) begin
      bus1.req_a = (s == 0);
      bus1.req_b = (s == 1);
      tick();
      for (int ab = 0; ab < 4; ab++) begin
        av = ab[1];
        bv = ab[0];
        bus1.a = av;
        bus1.b = bv;
        yv = (s == 1) ? bv : av;
        expQ.push_back(mk(s == 0, s == 1, s == 1, 1'b1, {7'd0, yv}));
        #1;
        exp = expQ.pop_front();
        got = obs1();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("[TB] FAIL mux_sweep sel=%0d a=%b b=%b: got gA/gB/sel/vld=%b y=%h, want %b y=%h",
                   s, av, bv, got[11:8], got[7:0], exp[11:8], exp[7:0]);
        end
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus0.req_a = 1'b0;
    bus0.req_b = 1'b0;
    bus0.a     = '0;
    bus0.b     = '0;
    bus1.req_a = 1'b0;
    bus1.req_b = 1'b0;
    bus1.a     = '0;
    bus1.b     = '0;
    $display("[TB] starting mux_arbiter scenarios");
    test_reset();
    tick();
    test_single_a();
    test_tie();
    test_handover();
    test_idle();
    test_idle_tie();
    test_reset_mid();
    test_alternate();
    test_mux_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester path and of y.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive grant cycles while the other side is requesting; legal range 1..15.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_a  input  1  requester A wants the shared path.
REQ-007 req_b  input  1  requester B wants the shared path.
REQ-008 a  input  WIDTH  requester A data.
REQ-009 b  input  WIDTH  requester B data.
REQ-010 gnt_a  output  1  A owns the path this cycle (registered).
REQ-011 gnt_b  output  1  B owns the path this cycle (registered).
REQ-012 sel  output  1  mux select: 0 = a, 1 = b (registered).
REQ-013 y  output  WIDTH  selected data, combinational from sel, a and b.
REQ-014 y_valid  output  1  gnt_a OR gnt_b.

Function
REQ-015 FSM states: IDLE, GNT_A, GNT_B; gnt_a = (state == GNT_A), gnt_b = (state == GNT_B); never both high.
REQ-016 Latency: a request sampled at edge n SHALL produce a grant visible after edge n+1 (one cycle); there is no combinational req-to-gnt path.
REQ-017 IDLE: only req_a -> GNT_A; only req_b -> GNT_B; both -> the side not named by last_gnt; neither -> stay IDLE.
REQ-018 GNT_A: req_a low and req_b high -> GNT_B directly, with no IDLE bubble; both low -> IDLE.
REQ-019 GNT_A: req_a and req_b high with hold_cnt == MAX_HOLD-1 -> forced handover to GNT_B; otherwise stay.
REQ-020 GNT_B: mirror of REQ-018/019 with A and B swapped.
REQ-021 hold_cnt (4 bits) SHALL be cleared on every grant entry and increment each cycle in the same grant state, saturating at MAX_HOLD-1.
REQ-022 With no competing request, a grant SHALL be held indefinitely.
REQ-023 last_gnt SHALL update to the side being granted on every entry to GNT_A or GNT_B.
REQ-024 sel SHALL be 0 in GNT_A and 1 in GNT_B, and SHALL keep its last value in IDLE.
REQ-025 y SHALL equal a when sel=0 and b when sel=1, bit for bit.
REQ-026 MAX_HOLD=1 with both requests held: the grant alternates A, B, A, ... every cycle.

Reset
REQ-027 While rst_n is low: state=IDLE, gnt_a=0, gnt_b=0, sel=0, y_valid=0, hold_cnt=0, last_gnt=B (so A wins the first tie).
REQ-028 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), without waiting for a clock edge.
REQ-029 After release, the first grant SHALL follow REQ-016 timing from the first sampling edge.

Structure
REQ-030 Package mux_arbiter_pkg SHALL hold the state enum (IDLE=2'b00, GNT_A=2'b01, GNT_B=2'b10) and the default WIDTH/MAX_HOLD constants.
REQ-031 The datapath SHALL be WIDTH instances of the existing 2:1 gate-level mux (inputs a, b, sel; output y), generated per bit; no behavioural select.
REQ-032 The FSM, hold_cnt and last_gnt SHALL be in mux_arbiter itself; no other sub-modules.

Verification
REQ-033 Reset then req_a=1 only, a=8'h3C -> after 1 edge gnt_a=1, sel=0, y=8'h3C, y_valid=1.
REQ-034 From reset, req_a=req_b=1 held, MAX_HOLD=4 -> gnt_a for 4 cycles, gnt_b for 4 cycles, repeating; never both high.
REQ-035 GNT_A, req_a drops while req_b=1, b=8'hA5 -> next edge gnt_b=1, sel=1, y=8'hA5, no idle cycle.
REQ-036 Both requests drop -> IDLE, y_valid=0, sel unchanged; then a single req_b -> gnt_b after 1 edge.
REQ-037 rst_n pulsed low mid-GNT_B -> gnt_b=0, sel=0 immediately; after release with a tie, A wins.
REQ-038 Exhaustive a/b/sel sweep at WIDTH=1 (8 combinations) -> y matches the mux truth table in every case.
